// File: rtl/pop_acc_thresh_pkg.sv
// Shared types, default widths and width helpers for the
// popcount accumulate-and-threshold stage.
package pop_acc_pkg;

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    localparam int POP_W_DEF     = 10;
    localparam int ACC_W_DEF     = 16;
    localparam int BEATS_MAX_DEF = 64;

    function automatic int pop_width(input int pop_size);
        return $clog2(pop_size + 1);
    endfunction

    function automatic int cnt_width(input int beats_max);
        return $clog2(beats_max + 1);
    endfunction

endpackage

// File: rtl/pop_acc_thresh_if.sv
// Popcount beat channel in, activation result channel out.
// master drives beats and accepts results; slave is the accumulator.
interface pop_acc_thresh_if
    import pop_acc_pkg::*;
#(
    parameter int POP_W = POP_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic             pop_valid;
    logic             pop_ready;
    logic [POP_W-1:0] pop_in;
    logic             pop_last;
    logic [ACC_W-1:0] thr;
    logic             act_valid;
    logic             act_ready;
    logic             act_bit;
    logic [ACC_W-1:0] act_sum;
    logic             act_sat;
    logic             act_forced;

    modport master (
        output pop_valid, pop_in, pop_last, thr, act_ready,
        input  pop_ready, act_valid, act_bit, act_sum,
        input  act_sat, act_forced
    );

    modport slave (
        input  pop_valid, pop_in, pop_last, thr, act_ready,
        output pop_ready, act_valid, act_bit, act_sum,
        output act_sat, act_forced
    );

endinterface

// File: rtl/pop_acc_thresh_sat_add.sv
// Saturating accumulator adder: a + zero-extended b, clamped
// to all-ones on carry out of ACC_W bits.
module pop_sat_add #(
    parameter int POP_W = 10,
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] a,
    input  logic [POP_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    logic [ACC_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + (ACC_W+1)'(b);
        ovf = raw[ACC_W];
        sum = ovf ? '1 : raw[ACC_W-1:0];
    end

endmodule

// File: rtl/pop_acc_thresh.sv
// Accumulates per-chunk popcounts of one neuron, thresholds the
// group total and emits one activation bit plus the raw sum.
module pop_acc_thresh
    import pop_acc_pkg::*;
#(
    parameter int POP_W     = pop_width(576),
    parameter int ACC_W     = ACC_W_DEF,
    parameter int BEATS_MAX = BEATS_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    pop_acc_thresh_if.slave bus
);
    localparam int CNT_W = cnt_width(BEATS_MAX);

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] thr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [ACC_W-1:0] sum_now;
    logic [ACC_W-1:0] thr_now;
    logic [CNT_W-1:0] cnt_now;
    logic             sat_now;
    logic             first;
    logic             full;
    logic             pop_ready;
    logic             accept;
    logic             closing;

    logic             act_bit_q;
    logic [ACC_W-1:0] act_sum_q;
    logic             act_sat_q;
    logic             act_forced_q;

    pop_sat_add #(
        .POP_W(POP_W),
        .ACC_W(ACC_W)
    ) u_add (
        .a  (acc_q),
        .b  (bus.pop_in),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    // A result waiting in HOLD only blocks beats while act_ready is low.
    assign pop_ready = rst_n & ((state_q == ACC) | bus.act_ready);
    assign accept    = bus.pop_valid & pop_ready;

    always_comb begin
        first   = (cnt_q == '0);
        sum_now = first ? ACC_W'(bus.pop_in) : add_sum;
        sat_now = ~first & (sat_q | add_ovf);
        thr_now = first ? bus.thr : thr_q;
        cnt_now = first ? CNT_W'(1) : cnt_q + 1'b1;
        full    = (cnt_now == CNT_W'(BEATS_MAX));
        closing = accept & (bus.pop_last | full);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:     if (closing) state_d = HOLD;
            HOLD:    if (bus.act_ready & ~closing) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACC;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            thr_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            act_bit_q    <= 1'b0;
            act_sum_q    <= '0;
            act_sat_q    <= 1'b0;
            act_forced_q <= 1'b0;
        end else begin
            if (accept) begin
                thr_q <= thr_now;
                if (closing) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    sat_q <= 1'b0;
                end else begin
                    acc_q <= sum_now;
                    cnt_q <= cnt_now;
                    sat_q <= sat_now;
                end
            end
            if (closing) begin
                act_sum_q    <= sum_now;
                act_bit_q    <= (sum_now >= thr_now);
                act_sat_q    <= sat_now;
                act_forced_q <= full & ~bus.pop_last;
            end
        end
    end

    assign bus.pop_ready  = pop_ready;
    assign bus.act_valid  = (state_q == HOLD);
    assign bus.act_bit    = act_bit_q;
    assign bus.act_sum    = act_sum_q;
    assign bus.act_sat    = act_sat_q;
    assign bus.act_forced = act_forced_q;

endmodule

// File: tb/tb_pop_acc_thresh.sv
// Bench for pop_acc_thresh: scoreboard of expected group results
// plus per-scenario inline checks on timing and stall behaviour.
module tb_pop_acc_thresh;
    import pop_acc_pkg::*;

    typedef struct {
        logic [15:0] sum;
        logic        hit;
        logic        sat;
        logic        forced;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t q10[$];
    exp_t mon_e;
    exp_t mon_e10;

    always #5 clk = ~clk;

    pop_acc_thresh_if #(.POP_W(10), .ACC_W(16)) bus();
    pop_acc_thresh_if #(.POP_W(10), .ACC_W(10)) bus10();

    pop_acc_thresh #(
        .POP_W(10), .ACC_W(16), .BEATS_MAX(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    pop_acc_thresh #(
        .POP_W(10), .ACC_W(10), .BEATS_MAX(64)
    ) dut10 (
        .clk(clk), .rst_n(rst_n), .bus(bus10)
    );

    always @(negedge clk) begin
        if (rst_n && bus.act_valid && bus.act_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result sum=%0d", bus.act_sum);
            end else begin
                mon_e = q.pop_front();
                if (bus.act_sum !== mon_e.sum || bus.act_bit !== mon_e.hit ||
                    bus.act_sat !== mon_e.sat || bus.act_forced !== mon_e.forced) begin
                    errors++;
                    $display("FAIL result got sum=%0d bit=%b sat=%b forced=%b exp sum=%0d bit=%b sat=%b forced=%b",
                             bus.act_sum, bus.act_bit, bus.act_sat, bus.act_forced,
                             mon_e.sum, mon_e.hit, mon_e.sat, mon_e.forced);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus10.act_valid && bus10.act_ready) begin
            checks++;
            if (q10.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result10 sum=%0d", bus10.act_sum);
            end else begin
                mon_e10 = q10.pop_front();
                if (16'(bus10.act_sum) !== mon_e10.sum || bus10.act_bit !== mon_e10.hit ||
                    bus10.act_sat !== mon_e10.sat || bus10.act_forced !== mon_e10.forced) begin
                    errors++;
                    $display("FAIL result10 got sum=%0d bit=%b sat=%b forced=%b exp sum=%0d bit=%b sat=%b forced=%b",
                             bus10.act_sum, bus10.act_bit, bus10.act_sat, bus10.act_forced,
                             mon_e10.sum, mon_e10.hit, mon_e10.sat, mon_e10.forced);
                end
            end
        end
    end

    task automatic send(input bit sel, input int v, input bit last);
        int n;
        if (!sel) begin
            bus.pop_valid = 1'b1;
            bus.pop_in    = 10'(v);
            bus.pop_last  = last;
        end else begin
            bus10.pop_valid = 1'b1;
            bus10.pop_in    = 10'(v);
            bus10.pop_last  = last;
        end
        n = 0;
        @(negedge clk);
        while (!(sel ? bus10.pop_ready : bus.pop_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout got ready=0 exp ready=1 value=%0d", v);
        end
        @(posedge clk);
        #1;
        bus.pop_valid   = 1'b0;
        bus.pop_last    = 1'b0;
        bus10.pop_valid = 1'b0;
        bus10.pop_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q10.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.pop_ready, bus.act_valid, bus.act_bit, bus.act_sum,
             bus.act_sat, bus.act_forced} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b bit=%b sum=%0d sat=%b f=%b exp all 0",
                     bus.pop_ready, bus.act_valid, bus.act_bit, bus.act_sum,
                     bus.act_sat, bus.act_forced);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.pop_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b exp 1", bus.pop_ready);
        end
    endtask

    task automatic test_basic();
        bus.act_ready = 1'b1;
        bus.thr = 16'd300;
        q.push_back('{16'd350, 1'b1, 1'b0, 1'b0});
        send(0, 100, 0);
        send(0, 200, 0);
        send(0, 50, 1);
        checks++;
        if (bus.act_valid !== 1'b1 || bus.act_sum !== 16'd350) begin
            errors++;
            $display("FAIL latency got v=%b sum=%0d exp v=1 sum=350",
                     bus.act_valid, bus.act_sum);
        end
        drain();
    endtask

    task automatic test_thr_latch();
        bus.thr = 16'd351;
        q.push_back('{16'd350, 1'b0, 1'b0, 1'b0});
        send(0, 100, 0);
        bus.thr = 16'd0;
        send(0, 200, 0);
        send(0, 50, 1);
        drain();
    endtask

    task automatic test_sat();
        bus10.act_ready = 1'b1;
        bus10.thr = 10'd1000;
        q10.push_back('{16'd1023, 1'b1, 1'b1, 1'b0});
        send(1, 576, 0);
        send(1, 576, 1);
        drain();
    endtask

    task automatic test_forced();
        bus.thr = 16'd64;
        q.push_back('{16'd64, 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 64; i++) send(0, 1, 0);
        bus.thr = 16'd5;
        q.push_back('{16'd5, 1'b1, 1'b0, 1'b0});
        send(0, 5, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        bus.act_ready = 1'b0;
        bus.thr = 16'd20;
        q.push_back('{16'd30, 1'b1, 1'b0, 1'b0});
        q.push_back('{16'd7, 1'b1, 1'b0, 1'b0});
        q.push_back('{16'd9, 1'b1, 1'b0, 1'b0});
        send(0, 10, 0);
        send(0, 20, 1);
        bus.pop_valid = 1'b1;
        bus.pop_in = 10'd7;
        bus.pop_last = 1'b1;
        bus.thr = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.act_valid !== 1'b1 || bus.act_sum !== 16'd30 ||
                bus.act_bit !== 1'b1 || bus.act_sat !== 1'b0 ||
                bus.act_forced !== 1'b0 || bus.pop_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall cyc=%0d got v=%b sum=%0d bit=%b rdy=%b exp v=1 sum=30 bit=1 rdy=0",
                         i, bus.act_valid, bus.act_sum, bus.act_bit, bus.pop_ready);
            end
        end
        @(posedge clk);
        #1;
        bus.act_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pop_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_follow got %b exp 1", bus.pop_ready);
        end
        @(posedge clk);
        #1;
        bus.pop_in = 10'd9;
        @(negedge clk);
        checks++;
        if (bus.act_valid !== 1'b1 || bus.act_sum !== 16'd7) begin
            errors++;
            $display("FAIL b2b_first got v=%b sum=%0d exp v=1 sum=7",
                     bus.act_valid, bus.act_sum);
        end
        @(posedge clk);
        #1;
        bus.pop_valid = 1'b0;
        bus.pop_last = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.act_valid !== 1'b1 || bus.act_sum !== 16'd9) begin
            errors++;
            $display("FAIL b2b_second got v=%b sum=%0d exp v=1 sum=9",
                     bus.act_valid, bus.act_sum);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.act_valid !== 1'b0) begin
            errors++;
            $display("FAIL retire got v=%b exp 0", bus.act_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.act_ready = 1'b1;
        send(0, 40, 0);
        send(0, 40, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pop_ready, bus.act_valid, bus.act_bit, bus.act_sum,
             bus.act_sat, bus.act_forced} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b v=%b sum=%0d exp all 0",
                     bus.pop_ready, bus.act_valid, bus.act_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.thr = 16'd10;
        q.push_back('{16'd10, 1'b1, 1'b0, 1'b0});
        send(0, 10, 1);
        drain();
        bus.act_ready = 1'b0;
        bus.thr = 16'd0;
        send(0, 5, 1);
        checks++;
        if (bus.act_valid !== 1'b1 || bus.act_sum !== 16'd5) begin
            errors++;
            $display("FAIL hold_entry got v=%b sum=%0d exp v=1 sum=5",
                     bus.act_valid, bus.act_sum);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.act_valid, bus.act_bit, bus.act_sum} !== 18'd0) begin
            errors++;
            $display("FAIL reset_hold got v=%b bit=%b sum=%0d exp all 0",
                     bus.act_valid, bus.act_bit, bus.act_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.pop_valid   = 1'b0;
        bus.pop_in      = '0;
        bus.pop_last    = 1'b0;
        bus.thr         = '0;
        bus.act_ready   = 1'b0;
        bus10.pop_valid = 1'b0;
        bus10.pop_in    = '0;
        bus10.pop_last  = 1'b0;
        bus10.thr       = '0;
        bus10.act_ready = 1'b0;
        test_reset();
        test_basic();
        test_thr_latch();
        test_sat();
        test_forced();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (q.size() != 0 || q10.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d/%0d pending exp 0/0", q.size(), q10.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule

// File: doc/pop_acc_thresh.md
# pop_acc_thresh

Downstream consumer of the popcount stage in the binarized-layer datapath. Accumulates a stream of per-chunk popcounts (plain or majority-mode) belonging to one output neuron, compares the group total against a per-neuron threshold, and emits one binary activation plus the raw sum. Valid/ready handshakes on both sides let it sit between the popcount array and the activation packer without stalling either.

## Interface
- POP_W, 10, width of one incoming popcount (covers 0..576)
- ACC_W, 16, accumulator, threshold and sum width
- BEATS_MAX, 64, maximum beats per group; the BEATS_MAX-th beat closes the group
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pop_valid  in  1  popcount beat valid
- pop_ready  out  1  beat accepted when pop_valid & pop_ready
- pop_in  in  POP_W  popcount value, unsigned
- pop_last  in  1  final beat of the current group
- thr  in  ACC_W  threshold, unsigned; sampled on the first accepted beat of a group
- act_valid  out  1  result available
- act_ready  in  1  downstream accepts result
- act_bit  out  1  1 when group sum >= threshold
- act_sum  out  ACC_W  saturated group sum
- act_sat  out  1  accumulator saturated during the group
- act_forced  out  1  group closed by BEATS_MAX, not by pop_last

## Operation
- States: ACC (collecting beats), HOLD (result registered, waiting for act_ready).
- pop_ready = (state == ACC) | act_ready; forced 0 while rst_n low.
- First beat of a group: acc <= pop_in, thr_q <= thr, beat_cnt <= 1, sat flag cleared. Later beats: acc <= sat_add(acc, pop_in), beat_cnt++.
- Saturating add: on overflow of ACC_W bits acc holds 2^ACC_W-1 and the sat flag sets; it stays set until the group closes.
- Group closes on an accepted beat with pop_last = 1, or on the beat that makes beat_cnt == BEATS_MAX (act_forced = 1 unless pop_last is also 1).
- On close: act_sum, act_bit (sum incl. closing beat >= thr_q), act_sat and act_forced are registered; act_valid = 1; state -> HOLD.
- HOLD & act_ready & pop_valid in the same cycle: the result retires and the beat starts a new group. If that beat is also closing (single-beat group), act_valid stays 1 with the new result.
- HOLD & act_ready without pop_valid: act_valid -> 0; state -> ACC.
- act_* outputs are stable while act_valid = 1 and act_ready = 0.
- Reset (async, any time, including mid-group or in HOLD): state ACC, acc 0, beat_cnt 0, thr_q 0, act_valid 0, act_bit 0, act_sum 0, act_sat 0, act_forced 0. A partial group is discarded.

## Timing
- Latency: closing beat accepted at edge N -> act_valid high after edge N, with the result visible in cycle N+1.
- Throughput: 1 beat/cycle; back-to-back groups with no bubble when act_ready is held high.
- No combinational path from pop_valid, pop_in or thr to any act_* output; act_ready -> pop_ready is the only combinational path.
- thr changes mid-group have no effect on that group.

## Structure
- Package pop_acc_pkg: state enum {ACC, HOLD}, default width constants, a function computing POP_W from popcount size (clog2), and a function returning BEATS_MAX counter width.
- One sub-module, pop_sat_add: combinational ACC_W saturating adder (zero-extended POP_W operand), with an overflow output.
- Top: FSM, beat counter, threshold register, result registers.

## Test plan
- Beats 100, 200, 50 (last); thr = 300; act_ready = 1 -> one cycle after the last beat, act_sum = 350, act_bit = 1, act_sat = 0, act_forced = 0.
- Same stream with thr = 351, changed to 0 after the first beat -> act_bit = 0; thr_q was latched at 351.
- ACC_W = 10, beats 576, 576 (last) -> act_sum = 1023, act_sat = 1, act_bit = 1 for thr = 1000.
- 64 beats of 1 without pop_last -> act_forced = 1, act_sum = 64; the 65th beat starts a new group.
- act_ready = 0 for 5 cycles after close -> act_* stable, pop_ready = 0; pop_valid held high; the beat is accepted in the act_ready cycle. Single-beat groups (pop_last = 1) of value 7 and 9 back-to-back -> act_valid stays high, act_sum goes 7 then 9 on consecutive cycles.
- rst_n pulsed low mid-group, after two beats of 40 -> all outputs 0 immediately; next group 10 (last) gives act_sum = 10.
